// File: rtl/k423_pkg.sv
// k423_pkg: shared core widths and the fetch-to-decode entry type.
package k423_pkg;
   localparam int CORE_ADDR_W = 32;
   localparam int CORE_DATA_W = 32;
   typedef struct packed {
      logic [CORE_ADDR_W-1:0] pc;
      logic [CORE_DATA_W-1:0] inst;
   } ibuf_entry_t;
endpackage

// File: rtl/k423_sync_fifo.sv
// k423_sync_fifo: generic in-order FIFO with flush, full/empty and occupancy count.
module k423_sync_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) mem[wr_ptr] <= wdata;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end
   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (count <= CNT_W'(DEPTH));
         assert (!(push && full && !flush));
         assert (!(pop && empty && !flush));
      end
   end
endmodule

// File: rtl/k423_if_ibuf.sv
// k423_if_ibuf: fetch-to-decode instruction buffer; qualifies push/pop and
// lets a pipeline clear discard everything, including same-cycle traffic.
module k423_if_ibuf
   import k423_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   pcu_clear_if_i,
   input  logic                   pc_stage_vld_i,
   input  logic                   if_mem_rsp_vld_i,
   input  logic [CORE_ADDR_W-1:0] pc_i,
   input  logic [CORE_DATA_W-1:0] inst_i,
   output logic                   if_stage_rdy_o,
   input  logic                   id_stage_rdy_i,
   output logic                   if_stage_vld_o,
   output logic [CORE_ADDR_W-1:0] if_pc_o,
   output logic [CORE_DATA_W-1:0] if_inst_o,
   output logic [CNT_W-1:0]       ibuf_cnt_o
);
   ibuf_entry_t wr_entry, rd_entry;
   logic        push, pop, full, empty;
   assign wr_entry = '{pc: pc_i, inst: inst_i};
   assign push = pc_stage_vld_i & if_mem_rsp_vld_i & if_stage_rdy_o & ~pcu_clear_if_i;
   assign pop  = if_stage_vld_o & id_stage_rdy_i & ~pcu_clear_if_i;
   // ready comes from registered occupancy only, so a full buffer cannot refill on the pop cycle
   assign if_stage_rdy_o = ~full;
   assign if_stage_vld_o = ~empty;
   assign if_pc_o   = rd_entry.pc;
   assign if_inst_o = rd_entry.inst;
   k423_sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ibuf_entry_t))) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .flush (pcu_clear_if_i),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (full),
      .empty (empty),
      .count (ibuf_cnt_o)
   );
endmodule

// File: tb/tb_k423_if_ibuf.sv
// tb_k423_if_ibuf: directed scoreboard bench for the fetch-to-decode instruction buffer.
module tb_k423_if_ibuf;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0, pv = 1'b0, mv = 1'b0, idr = 1'b0;
   logic [31:0] pc = '0, inst = '0;
   logic        rdy, vld;
   logic [31:0] o_pc, o_inst;
   logic [1:0]  cnt;
   int          n_cmp = 0, n_err = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   k423_if_ibuf #(.DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .pcu_clear_if_i   (clr),
      .pc_stage_vld_i   (pv),
      .if_mem_rsp_vld_i (mv),
      .pc_i             (pc),
      .inst_i           (inst),
      .if_stage_rdy_o   (rdy),
      .id_stage_rdy_i   (idr),
      .if_stage_vld_o   (vld),
      .if_pc_o          (o_pc),
      .if_inst_o        (o_inst),
      .ibuf_cnt_o       (cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive one cycle after a negedge, check against the queue model, then advance
   task automatic step(input logic p, input logic m, input logic [31:0] a, input logic d, input logic c);
      logic acc;
      pv = p; mv = m; pc = a; inst = a ^ 32'h0000_0013; idr = d; clr = c;
      #1;
      chk("vld", 64'(vld), 64'(q.size() != 0));
      chk("rdy", 64'(rdy), 64'(q.size() != DEPTH));
      chk("cnt", 64'(cnt), 64'(q.size()));
      if (q.size() != 0) chk("head", {o_pc, o_inst}, q[0]);
      acc = p & m & (q.size() != DEPTH);
      if (c) q.delete();
      else begin
         if (d && q.size() != 0) void'(q.pop_front());
         if (acc) q.push_back({a, a ^ 32'h0000_0013});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2;
      chk("rst_vld", 64'(vld), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_out", {o_pc, o_inst}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // idle after reset
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         chk("idle_out", {o_pc, o_inst}, 64'd0);
      end
      // single push, seen one cycle later, popped immediately
      step(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // unqualified fetch (no memory response) is ignored
      step(1'b1, 1'b0, 32'h8000_0ff0, 1'b0, 1'b0);
      // fill to full, third offer rejected, then drain in order
      step(1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b0);
      chk("full_rdy", 64'(rdy), 64'd0);
      step(1'b1, 1'b1, 32'h8000_0008, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // steady stream with pointer wrap
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 32'h8000_1000 + 32'(i * 4), 1'b1, 1'b0);
         if (i > 0) chk("stream_cnt", 64'(cnt), 64'd1);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // flush with a concurrent push, then a fresh push is next out
      step(1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h8000_0014, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
      chk("flush_cnt", 64'(cnt), 64'd0);
      chk("flush_vld", 64'(vld), 64'd0);
      step(1'b1, 1'b1, 32'h8000_0200, 1'b0, 1'b0);
      chk("post_flush_pc", 64'(o_pc), 64'h8000_0200);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // asynchronous reset while full
      step(1'b1, 1'b1, 32'h8000_0300, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h8000_0304, 1'b0, 1'b0);
      chk("pre_arst_cnt", 64'(cnt), 64'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 64'(vld), 64'd0);
      chk("arst_cnt", 64'(cnt), 64'd0);
      chk("arst_out", {o_pc, o_inst}, 64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
